// File: rtl/btn_debounce_pulse_if.sv
//==============================================================================
// Module      : btn_debounce_pulse_if
// Description : Raw button pin plus conditioned level/pulse outputs for one button.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface btn_debounce_pulse_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic repeat_pulse;

  // master: the conditioner; slave: the pin source and pulse consumers
  modport master (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output repeat_pulse
  );

  modport slave (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  repeat_pulse
  );
endinterface

`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
//==============================================================================
// Module      : btn_debounce_pulse
// Description : Synchronise, debounce and pulse-encode one panel button.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 250,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  btn_debounce_pulse_if.master  btn
);

  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_db_last   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_rep_last  = CNT_W'(REPEAT_CYCLES - 1);
  localparam bit               c_rep_en    = (REPEAT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DB_PRESS   = 2'd1,
    ST_HELD       = 2'd2,
    ST_DB_RELEASE = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_db_cnt;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_rep_cnt;
  logic             r_long_done;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_long;
  logic             r_repeat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_db_cnt    <= '0;
      r_hold_cnt  <= '0;
      r_rep_cnt   <= '0;
      r_long_done <= 1'b0;
      r_level     <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_sync1   <= btn.btn_raw;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_sync2) begin
            r_state  <= ST_DB_PRESS;
            r_db_cnt <= c_one;
          end
        end

        ST_DB_PRESS: begin
          if (!r_sync2) begin
            r_state <= ST_IDLE;
          end else if (r_db_cnt == c_db_last) begin
            r_state     <= ST_HELD;
            r_press     <= 1'b1;
            r_level     <= 1'b1;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + c_one;
          end
        end

        ST_HELD: begin
          // A falling sync wins over any long/repeat pulse due this cycle
          if (!r_sync2) begin
            r_state  <= ST_DB_RELEASE;
            r_db_cnt <= c_one;
          end else begin
            if (r_hold_cnt != '1) begin
              r_hold_cnt <= r_hold_cnt + c_one;
            end
            if (r_hold_cnt == c_long_last && !r_long_done) begin
              r_long      <= 1'b1;
              r_long_done <= 1'b1;
              r_rep_cnt   <= '0;
            end else if (r_long_done && c_rep_en) begin
              if (r_rep_cnt == c_rep_last) begin
                r_repeat  <= 1'b1;
                r_rep_cnt <= '0;
              end else begin
                r_rep_cnt <= r_rep_cnt + c_one;
              end
            end
          end
        end

        ST_DB_RELEASE: begin
          // Bounce back to HELD resumes the frozen hold/repeat counters
          if (r_sync2) begin
            r_state <= ST_HELD;
          end else if (r_db_cnt == c_db_last) begin
            r_state   <= ST_IDLE;
            r_release <= 1'b1;
            r_level   <= 1'b0;
          end else begin
            r_db_cnt <= r_db_cnt + c_one;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign btn.btn_level     = r_level;
  assign btn.press_pulse   = r_press;
  assign btn.release_pulse = r_release;
  assign btn.long_pulse    = r_long;
  assign btn.repeat_pulse  = r_repeat;

endmodule

`default_nettype wire
